// File: rtl/barrel_shifter8_lsl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : barrel_shifter8_lsl_pipe                                     |
// | Description : Pipelined logical-shift-left barrel shifter, one registered  |
// |               stage per shift-amount bit, valid/ready on both sides.       |
// |               Optional rotate-left mode enabled by BSH_LSL_ROTATE_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module barrel_shifter8_lsl_pipe #(
  parameter int  DATA_W  = 8,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
`ifdef BSH_LSL_ROTATE_EN
  input  logic               in_rot,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_ovf
);

  // w_rdy[k] is the capture enable of stage k; w_rdy[SHAMT_W] is the sink.
  logic [SHAMT_W:0] w_rdy;

  assign w_rdy[SHAMT_W] = out_ready;
  assign in_ready       = w_rdy[0];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int c_step = 1 << k;

    logic               w_src_valid;
    logic [DATA_W-1:0]  w_src_data;
    logic [SHAMT_W-1:0] w_src_shamt;
    logic               w_src_ovf;
    logic               w_src_rot;

    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [SHAMT_W-1:0] r_shamt;
    logic               r_ovf;

    logic [c_step-1:0]  w_lost;
    logic [c_step-1:0]  w_fill;
    logic [DATA_W-1:0]  w_nxt_data;
    logic               w_nxt_ovf;

    if (k == 0) begin : g_head
      assign w_src_valid = in_valid;
      assign w_src_data  = in_data;
      assign w_src_shamt = in_shamt;
      assign w_src_ovf   = 1'b0;
    end else begin : g_body
      assign w_src_valid = g_stage[k-1].r_valid;
      assign w_src_data  = g_stage[k-1].r_data;
      assign w_src_shamt = g_stage[k-1].r_shamt;
      assign w_src_ovf   = g_stage[k-1].r_ovf;
    end

`ifdef BSH_LSL_ROTATE_EN
    logic r_rot;
    logic w_unused_stage;

    if (k == 0) begin : g_rot_head
      assign w_src_rot = in_rot;
    end else begin : g_rot_body
      assign w_src_rot = g_stage[k-1].r_rot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rot <= 1'b0;
      end else if (w_rdy[k] && w_src_valid) begin
        r_rot <= w_src_rot;
      end
    end

    // The final stage's shamt/rot copies have no consumer downstream.
    assign w_unused_stage = ^{r_shamt, r_rot};
`else
    logic w_unused_stage;

    assign w_src_rot      = 1'b0;
    assign w_unused_stage = ^r_shamt;
`endif

    // Bits leaving the MSB end either wrap around (rotate) or are counted as overflow.
    assign w_lost = w_src_data[DATA_W-1 -: c_step];
    assign w_fill = w_src_rot ? w_lost : '0;

    always_comb begin
      w_nxt_data = w_src_data;
      w_nxt_ovf  = w_src_ovf;
      if (w_src_shamt[k]) begin
        w_nxt_data = {w_src_data[DATA_W-1-c_step:0], w_fill};
        w_nxt_ovf  = w_src_ovf | (|w_lost);
      end
      if (w_src_rot) begin
        w_nxt_ovf = 1'b0;
      end
    end

    assign w_rdy[k] = !r_valid || w_rdy[k+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_shamt <= '0;
        r_ovf   <= 1'b0;
      end else if (w_rdy[k]) begin
        r_valid <= w_src_valid;
        // Bubbles advance the valid bit only; payload keeps its last value.
        if (w_src_valid) begin
          r_data  <= w_nxt_data;
          r_shamt <= w_src_shamt;
          r_ovf   <= w_nxt_ovf;
        end
      end
    end
  end

  assign out_valid = g_stage[SHAMT_W-1].r_valid;
  assign out_data  = g_stage[SHAMT_W-1].r_data;
  assign out_ovf   = g_stage[SHAMT_W-1].r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter8_lsl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_barrel_shifter8_lsl_pipe                                  |
// | Description : Directed self-checking bench for barrel_shifter8_lsl_pipe.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_barrel_shifter8_lsl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
`ifdef BSH_LSL_ROTATE_EN
  logic       in_rot;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barrel_shifter8_lsl_pipe #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
`ifdef BSH_LSL_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_shamt  = 3'd0;
    out_ready = 1'b1;
`ifdef BSH_LSL_ROTATE_EN
    in_rot    = 1'b0;
`endif
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data got %h exp 00", out_data);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'h81; in_shamt = 3'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready got %b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0; in_data = 8'hFF; in_shamt = 3'd7;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL single_early_valid cycle %0d got %b exp 0", i, out_valid);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency got out_valid %b exp 1", out_valid);
    end
    checks++;
    if (out_data !== 8'h02 || out_ovf !== 1'b1) begin
      errors++; $display("FAIL single_result got %h/%b exp 02/1", out_data, out_ovf);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got out_valid %b exp 0", out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] din  [9] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF};
    logic [2:0] sh   [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    logic [7:0] edat [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80};
    logic       eovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int got   = 0;
    int first = -1;
    int last  = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c < 9) begin
        in_valid = 1'b1; in_data = din[c]; in_shamt = sh[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 9) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL sweep_in_ready beat %0d got %b exp 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 9) begin
          errors++; $display("FAIL sweep_extra_beat got %h exp none", out_data);
        end else if (out_data !== edat[got] || out_ovf !== eovf[got]) begin
          errors++;
          $display("FAIL sweep_result beat %0d got %h/%b exp %h/%b",
                   got, out_data, out_ovf, edat[got], eovf[got]);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      step();
    end
    checks++;
    if (got != 9) begin
      errors++; $display("FAIL sweep_count got %0d exp 9", got);
    end
    checks++;
    if (last - first != 8) begin
      errors++; $display("FAIL sweep_back_to_back span got %0d exp 8", last - first);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] din  [5] = '{8'h11, 8'h90, 8'h03, 8'hF0, 8'h55};
    logic [2:0] sh   [5] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd3};
    logic [7:0] edat [5] = '{8'h22, 8'h20, 8'h0C, 8'h00, 8'hA8};
    logic       eovf [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int  sent = 0;
    int  got  = 0;
    logic acc;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (sent < 5);
      if (sent < 5) begin
        in_data = din[sent]; in_shamt = sh[sent];
      end
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    #1;
    checks++;
    if (sent != 3) begin
      errors++; $display("FAIL bp_accepts_when_stalled got %0d exp 3", sent);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_full got %b exp 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got %b/%h/%b exp 1/22/0", i, out_valid, out_data, out_ovf);
      end
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (sent < 5);
      if (sent < 5) begin
        in_data = din[sent]; in_shamt = sh[sent];
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 5) begin
          errors++; $display("FAIL bp_duplicate got %h exp none", out_data);
        end else if (out_data !== edat[got] || out_ovf !== eovf[got]) begin
          errors++;
          $display("FAIL bp_order beat %0d got %h/%b exp %h/%b",
                   got, out_data, out_ovf, edat[got], eovf[got]);
        end
        got++;
      end
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 5 || got != 5) begin
      errors++; $display("FAIL bp_count sent %0d got %0d exp 5/5", sent, got);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h0F + 8'(i); in_shamt = 3'(i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset_valid got %b exp 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL mid_async_reset got %b/%h exp 0/00", out_valid, out_data);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL mid_stale_beats got %0d exp 0", stale);
    end
  endtask

`ifdef BSH_LSL_ROTATE_EN
  task automatic test_rotate();
    logic [7:0] din  [3] = '{8'h81, 8'h81, 8'h12};
    logic [2:0] sh   [3] = '{3'd1, 3'd1, 3'd4};
    logic       rot  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] edat [3] = '{8'h03, 8'h02, 8'h21};
    logic       eovf [3] = '{1'b0, 1'b1, 1'b0};
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin
        in_data = din[c]; in_shamt = sh[c]; in_rot = rot[c];
      end
      #1;
      if (out_valid === 1'b1 && got < 3) begin
        checks++;
        if (out_data !== edat[got] || out_ovf !== eovf[got]) begin
          errors++;
          $display("FAIL rotate_result beat %0d got %h/%b exp %h/%b",
                   got, out_data, out_ovf, edat[got], eovf[got]);
        end
        got++;
      end
      step();
    end
    in_valid = 1'b0;
    in_rot   = 1'b0;
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL rotate_count got %0d exp 3", got);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_reset_mid();
`ifdef BSH_LSL_ROTATE_EN
    test_rotate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
